// File: rtl/sync_pkg.sv
// Shared types and helpers for the multi-channel CDC synchroniser.
package sync_pkg;

  typedef enum logic {
    SYNC_LEVEL  = 1'b0,
    SYNC_TOGGLE = 1'b1
  } sync_mode_e;

  localparam int SYNC_MIN_STAGES = 2;

  // Filter counter width; never narrower than one bit so the vector stays legal.
  function automatic int sync_cnt_width(input int filt_len);
    int w;
    w = $clog2(filt_len + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_chan.sv
// One synchroniser channel: metastability chain, glitch filter, edge detect, sticky flag.
// Sticky flag is only built when SYNC_MULTI_STICKY_EN is defined.
import sync_pkg::*;

module sync_chan #(
  parameter int   STAGES   = 2,
  parameter int   MODE     = 0,
  parameter int   FILT_LEN = 0,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic sticky_clr,
  output logic level_out,
  output logic rise,
  output logic fall,
  output logic pulse,
  output logic sticky
);

  localparam int CW = sync_cnt_width(FILT_LEN);

  logic [STAGES-1:0] chain;
  logic              sync_lvl;
  logic              level_d;

  if (STAGES < SYNC_MIN_STAGES) begin : g_stage_chk
    $error("sync_chan: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], async_in};
  end

  assign sync_lvl = chain[STAGES-1];

  if (FILT_LEN == 0) begin : g_nofilt
    always_ff @(posedge clk) begin
      if (rst) level_out <= RST_VAL;
      else     level_out <= sync_lvl;
    end
  end else begin : g_filt
    logic [CW-1:0] cnt;

    // Any agreement restarts the run, so short glitches never reach level_out.
    always_ff @(posedge clk) begin
      if (rst) begin
        level_out <= RST_VAL;
        cnt       <= '0;
      end else if (sync_lvl == level_out) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level_out <= ~level_out;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) level_d <= RST_VAL;
    else     level_d <= level_out;
  end

  assign rise  = level_out & ~level_d;
  assign fall  = ~level_out & level_d;
  assign pulse = (MODE == int'(SYNC_TOGGLE)) ? (rise | fall) : rise;

`ifdef SYNC_MULTI_STICKY_EN
  // Set has priority over clear so an event coinciding with a clear is kept.
  always_ff @(posedge clk) begin
    if (rst)             sticky <= 1'b0;
    else if (pulse)      sticky <= 1'b1;
    else if (sticky_clr) sticky <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = sticky_clr;
  assign sticky     = 1'b0;
`endif

endmodule

// File: rtl/synchronizer_multi.sv
// Multi-channel CDC synchroniser top: one independent sync_chan per channel.
// Optional sticky event flags are enabled by SYNC_MULTI_STICKY_EN.
import sync_pkg::*;

module synchronizer_multi #(
  parameter int                CHANNELS  = 4,
  parameter int                STAGES    = 2,
  parameter int                MODE      = 0,
  parameter int                FILT_LEN  = 0,
  parameter logic [CHANNELS-1:0] RST_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] sticky,
  input  logic [CHANNELS-1:0] sticky_clr
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_chan #(
      .STAGES   (STAGES),
      .MODE     (MODE),
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (RST_VALUE[i])
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .async_in   (async_in[i]),
      .sticky_clr (sticky_clr[i]),
      .level_out  (level_out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .pulse      (pulse[i]),
      .sticky     (sticky[i])
    );
  end

endmodule

// File: tb/tb_synchronizer_multi.sv
// Bench for synchronizer_multi: a filtered level-mode instance and an unfiltered toggle-mode instance.
module tb_synchronizer_multi;

  localparam int STG = 2;

  logic       clk;
  logic       rst;
  logic [3:0] ain_a, clr_a, ain_b, clr_b;
  logic [3:0] lvl_a, rise_a, fall_a, pulse_a, stk_a;
  logic [3:0] lvl_b, rise_b, fall_b, pulse_b, stk_b;

  int checks   = 0;
  int failures = 0;

  synchronizer_multi #(
    .CHANNELS(4), .STAGES(STG), .MODE(0), .FILT_LEN(3), .RST_VALUE(4'b0101)
  ) dut_a (
    .clk(clk), .rst(rst), .async_in(ain_a), .level_out(lvl_a), .rise(rise_a),
    .fall(fall_a), .pulse(pulse_a), .sticky(stk_a), .sticky_clr(clr_a)
  );

  synchronizer_multi #(
    .CHANNELS(4), .STAGES(STG), .MODE(1), .FILT_LEN(0), .RST_VALUE(4'b0000)
  ) dut_b (
    .clk(clk), .rst(rst), .async_in(ain_b), .level_out(lvl_b), .rise(rise_b),
    .fall(fall_b), .pulse(pulse_b), .sticky(stk_b), .sticky_clr(clr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: input/sync histories per channel, level flips once the last
  // FILT_LEN synchronised samples all disagree with it.
  logic [15:0] ah [2][4];
  logic [15:0] sh [2][4];
  logic        ml [2][4];
  logic        mlp[2][4];
  logic        ms [2][4];
  bit          mvalid = 0;

  function automatic int filt_of(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  function automatic logic rv_of(input int d, input int c);
    logic [3:0] v;
    v = (d == 0) ? 4'b0101 : 4'b0000;
    return v[c];
  endfunction

  function automatic logic mpulse(input int d, input int c);
    logic r, f;
    r = ml[d][c] & ~mlp[d][c];
    f = ~ml[d][c] & mlp[d][c];
    return (d == 0) ? r : (r | f);
  endfunction

  task automatic model_step();
    logic a, cl, sp, rv, all_diff;
    int   n;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        a  = (d == 0) ? ain_a[c] : ain_b[c];
        cl = (d == 0) ? clr_a[c] : clr_b[c];
        rv = rv_of(d, c);
        n  = filt_of(d);
        if (rst) begin
          ah[d][c]  = {16{rv}};
          sh[d][c]  = {16{rv}};
          ml[d][c]  = rv;
          mlp[d][c] = rv;
          ms[d][c]  = 1'b0;
        end else begin
          if (mpulse(d, c)) ms[d][c] = 1'b1;
          else if (cl)      ms[d][c] = 1'b0;
          sp        = ah[d][c][STG-1];
          sh[d][c]  = {sh[d][c][14:0], sp};
          mlp[d][c] = ml[d][c];
          if (n == 0) begin
            ml[d][c] = sp;
          end else begin
            all_diff = 1'b1;
            for (int k = 0; k < n; k++)
              if (sh[d][c][k] == ml[d][c]) all_diff = 1'b0;
            if (all_diff) ml[d][c] = ~ml[d][c];
          end
          ah[d][c] = {ah[d][c][14:0], a};
        end
      end
    end
    if (rst) mvalid = 1;
  endtask

  task automatic model_compare();
    logic [3:0] el, er, ef, ep, es;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        el[c] = ml[d][c];
        er[c] = ml[d][c] & ~mlp[d][c];
        ef[c] = ~ml[d][c] & mlp[d][c];
        ep[c] = mpulse(d, c);
`ifdef SYNC_MULTI_STICKY_EN
        es[c] = ms[d][c];
`else
        es[c] = 1'b0;
`endif
      end
      if (d == 0) begin
        chk("a_level", lvl_a, el);  chk("a_rise", rise_a, er);
        chk("a_fall", fall_a, ef);  chk("a_pulse", pulse_a, ep);
        chk("a_sticky", stk_a, es);
      end else begin
        chk("b_level", lvl_b, el);  chk("b_rise", rise_b, er);
        chk("b_fall", fall_b, ef);  chk("b_pulse", pulse_b, ep);
        chk("b_sticky", stk_b, es);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (mvalid) model_compare();
  end

  initial begin
    int np, nr, nf;
    bit sticky_en;
`ifdef SYNC_MULTI_STICKY_EN
    sticky_en = 1;
`else
    sticky_en = 0;
`endif
    rst   = 1'b1;
    ain_a = 4'b0101;
    ain_b = 4'b0000;
    clr_a = 4'b0000;
    clr_b = 4'b0000;

    // Reset for two edges, then the first cycle after release.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_level", lvl_a, 4'b0101);
    chk("rst_edges", rise_a | fall_a | pulse_a, 4'b0000);
    chk("rst_sticky", stk_a, 4'b0000);
    @(negedge clk);
    chk("post_rst_level", lvl_a, 4'b0101);
    chk("post_rst_edges", rise_a | fall_a | pulse_a, 4'b0000);

    // Bring channel 0 low, then a clean 0->1: capture edge E, sync at E+2, flip after three disagreeing edges (E+4).
    ain_a = 4'b0100;
    repeat (10) @(negedge clk);
    chk("ch0_low", 4'(lvl_a[0]), 4'd0);
    ain_a[0] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("ch0_rise_level", 4'(lvl_a[0]), 4'(j >= 4));
      chk("ch0_rise_pulse", 4'(rise_a[0]), 4'(j == 4));
      chk("ch0_no_fall", 4'(fall_a[0]), 4'd0);
    end

    // Channel 1: a 2-cycle high run is filtered out.
    ain_a[1] = 1'b1;
    repeat (2) @(negedge clk);
    ain_a[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("ch1_glitch_level", 4'(lvl_a[1]), 4'd0);
      chk("ch1_glitch_pulse", 4'(pulse_a[1]), 4'd0);
    end

    // Channel 1: a 3-cycle run passes, and the following low run of 3 brings it back.
    ain_a[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 2) ain_a[1] = 1'b0;
      chk("ch1_pass_level", 4'(lvl_a[1]), 4'((j >= 4) && (j < 7)));
    end

    // Reset while channel 0 has a partial count of 2.
    ain_a[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_level", lvl_a, 4'b0101);
    chk("midrst_edges", rise_a | fall_a | pulse_a, 4'b0000);
    chk("midrst_sticky", stk_a, 4'b0000);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("midrst_ch0_level", 4'(lvl_a[0]), 4'(j < 4));
      chk("midrst_ch0_fall", 4'(fall_a[0]), 4'(j == 4));
      chk("midrst_ch0_rise", 4'(rise_a[0]), 4'd0);
    end

    // Sticky on channel 3: rise visible after E+4, clear coincides with the pulse.
    ain_a[3] = 1'b1;
    repeat (5) @(negedge clk);
    chk("st_pulse3", 4'(pulse_a[3]), 4'd1);
    chk("st_before", 4'(stk_a[3]), 4'd0);
    clr_a[3] = 1'b1;
    @(negedge clk);
    chk("st_set_wins", 4'(stk_a[3]), 4'(sticky_en));
    @(negedge clk);
    chk("st_cleared", 4'(stk_a[3]), 4'd0);
    clr_a[3] = 1'b0;
    @(negedge clk);
    chk("st_idle", 4'(stk_a[3]), 4'd0);

    // Toggle mode on dut_b channel 2: four toggles, 8 cycles apart.
    np = 0; nr = 0; nf = 0;
    for (int t = 0; t < 4; t++) begin
      ain_b[2] = ~ain_b[2];
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        np += int'(pulse_b[2]);
        nr += int'(rise_b[2]);
        nf += int'(fall_b[2]);
      end
    end
    chk("tog_pulses", 4'(np), 4'd4);
    chk("tog_rises", 4'(nr), 4'd2);
    chk("tog_falls", 4'(nf), 4'd2);

    // Simultaneous transition on every channel of dut_b (latency STAGES edges).
    ain_b = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("simul_before", pulse_b, 4'h0);
    @(negedge clk);
    chk("simul_pulse", pulse_b, 4'hF);
    chk("simul_rise", rise_b, 4'hF);
    @(negedge clk);
    chk("simul_after", pulse_b, 4'h0);
    chk("simul_level", lvl_b, 4'hF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
